fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch front end that produces the instruction word, opcode and funct fields consumed by the control decoder, and acts on the decoder's jump output. Holds the fetch PC, issues one-outstanding-request reads to instruction memory over a req/ack interface, and buffers returned words in a small FIFO. Redirects fetch to a datapath-supplied target when jump is asserted.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 2, instruction FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned read address, valid while imem_req high
imem_ack  input  1  read complete this cycle; imem_data valid
imem_data  input  32  returned instruction word
jump  input  1  redirect request from the control decoder
jump_target  input  32  redirect address from the datapath, sampled when jump high
instr_valid  output  1  FIFO head valid
instr_ready  input  1  decode stage accepts head this cycle
instr  output  32  FIFO head instruction word
instr_pc  output  32  address of FIFO head instruction
opcode  output  6  instr[31:26]
funct  output  6  instr[5:0]

Behaviour:
- Reset (asynchronous, takes effect without a clock edge): imem_req=0, imem_addr=RESET_PC, fetch PC=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=RESET_PC, state=RUN. Any in-flight memory request is abandoned.
- States: RUN (normal issue) and FLUSH (an in-flight request is being discarded after a redirect).
- Issue rule: in RUN, imem_req is high when (FIFO count + outstanding) < DEPTH. imem_addr = fetch PC. Once asserted, imem_req and imem_addr stay stable until imem_ack.
- imem_ack is only honoured while imem_req is high. A same-cycle ack is legal.
- On ack in RUN without jump: {imem_data, imem_addr} is pushed into the FIFO and fetch PC += 4 (mod 2^32). imem_req stays high the next cycle if the issue rule still holds. Back-to-back acks therefore sustain one instruction per cycle.
- Latency: data acked in cycle N appears at the FIFO head (instr_valid=1) in cycle N+1 if the FIFO was empty. The first imem_req is high in the first cycle after rst deasserts.
- FIFO output: instr_valid = (count != 0). A pop occurs when instr_valid & instr_ready. A push and pop in the same cycle keep count unchanged. The reservation rule makes overflow impossible.
- Empty head: instr, instr_pc, opcode and funct hold their last value while instr_valid=0. opcode and funct are pure slices of instr.
- jump (checked every cycle; highest priority over push and pop):
  - The FIFO is cleared and fetch PC <= {jump_target[31:2], 2'b00}.
  - If a request is outstanding and not acked this cycle, go to FLUSH. In FLUSH, hold imem_req/imem_addr stable until ack, discard that data, then return to RUN.
  - If ack coincides with jump, the acked data is discarded and the FSM stays in RUN.
  - The next request goes to the target. Its instruction appears with instr_pc = target.
- jump while already in FLUSH: fetch PC is updated to the new target and the FSM remains in FLUSH.
- Misaligned jump_target: low 2 bits are forced to zero.

Test Plan:
- Release rst with RESET_PC=0, imem_ack tied high, imem_data=addr^32'hA5A5_0000 -> imem_req high in cycle 1. Instructions appear from cycle 2 with instr_pc 0,4,8,... at one per cycle; opcode/funct match data bits.
- instr_ready=0 after reset with ack tied high -> exactly 2 entries fetched (pc 0,4), then imem_req=0. Set instr_ready=1 -> pc 0,4,8 delivered in order with no gaps or duplicates.
- jump=1, jump_target=32'h0000_0040 with no request pending and FIFO holding 2 entries -> instr_valid=0 next cycle, next imem_addr=0x40, next delivered instr_pc=0x40.
- Ack delayed 3 cycles, jump to 0x80 in the 1st wait cycle -> imem_addr held at the old value until ack, returned word never reaches instr. Next request addr=0x80.
- jump coincident with imem_ack, target 0x100 -> acked word dropped, next instr_pc=0x100.
- Assert rst mid-request between clock edges -> imem_req=0, instr_valid=0, imem_addr=RESET_PC immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fetch_unit                                            |
// | Purpose  : Instruction fetch front end: PC, one-outstanding imem |
// |            reads, small instruction FIFO, jump redirect.         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    localparam int              c_PW        = $clog2(DEPTH);
    localparam int              c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic [31:0]     r_addr;
    logic [31:0]     r_pc;
    logic [31:0]     r_mem_data [DEPTH];
    logic [31:0]     r_mem_pc   [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_last_instr;
    logic [31:0]     r_last_pc;

    logic            w_ack;
    logic            w_hold;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_target;
    logic [31:0]     w_pc_next;
    logic [c_CW-1:0] w_count_next;
    logic [31:0]     w_instr;
    logic [31:0]     w_instr_pc;

    assign w_ack    = r_req & imem_ack;
    assign w_hold   = r_req & ~imem_ack;
    assign w_valid  = (r_count != '0);
    // Data returned while flushing, or in the cycle of a redirect, is stale.
    assign w_push   = w_ack & (r_state == ST_RUN) & ~jump;
    assign w_pop    = w_valid & instr_ready & ~jump;
    assign w_target = jump_target & 32'hFFFF_FFFC;

    assign w_pc_next = jump   ? w_target :
                       w_push ? r_pc + 32'd4 : r_pc;

    always_comb begin
        w_count_next = r_count;
        if (jump) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    // An empty FIFO keeps presenting the last head that was shown.
    assign w_instr    = w_valid ? r_mem_data[r_head] : r_last_instr;
    assign w_instr_pc = w_valid ? r_mem_pc[r_head]   : r_last_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_pc         <= RESET_PC;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_last_instr <= 32'h0000_0000;
            r_last_pc    <= RESET_PC;
        end else begin
            r_count      <= w_count_next;
            r_pc         <= w_pc_next;
            r_last_instr <= w_instr;
            r_last_pc    <= w_instr_pc;
            if (jump) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
            end
            // A pending request is frozen until acked; a new one reserves a FIFO slot.
            if (w_hold) begin
                if (jump) begin
                    r_state <= ST_FLUSH;
                end
            end else begin
                r_state <= ST_RUN;
                r_req   <= (w_count_next < c_DEPTH_CNT);
                r_addr  <= w_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_tail] <= imem_data;
            r_mem_pc[r_tail]   <= r_addr;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = w_valid;
    assign instr       = w_instr;
    assign instr_pc    = w_instr_pc;
    assign opcode      = w_instr[31:26];
    assign funct       = w_instr[5:0];

endmodule
`default_nettype wire
